// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond
//   Conditions two raw, asynchronous car-detector inputs (streets A and B)
//   into clean traffic-present flags for a downstream light controller and
//   counts debounced car arrivals per street.
//
//   Per channel: two-flop synchronizer -> debounce (level must persist
//   DEB_CYCLES consecutive edges) -> hold stretcher (flag stays up
//   HOLD_CYCLES edges after the debounced level falls) -> saturating
//   8-bit arrival counter.
//
// Ports
//   Clk        in   clock, all state changes on its rising edge
//   Rst_n      in   asynchronous active-low reset
//   SensA_raw  in   raw detector, street A (asynchronous)
//   SensB_raw  in   raw detector, street B (asynchronous)
//   Clr        in   synchronous clear of both arrival counters
//   Ta, Tb     out  registered traffic-present flags
//   CntA, CntB out  debounced arrival counts, saturate at 255
module traffic_sensor_cond #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       SensA_raw,
    input  logic       SensB_raw,
    input  logic       Clr,
    output logic       Ta,
    output logic       Tb,
    output logic [7:0] CntA,
    output logic [7:0] CntB
);

    // Mismatch count at which the next disagreeing edge accepts the new level.
    localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

    logic [1:0]      sens_raw;
    logic [1:0]      t_w;
    logic [1:0][7:0] cnt_w;

    assign sens_raw = {SensB_raw, SensA_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic       s1_q;
            logic       s2_q;
            logic       deb_q;
            logic       deb_d;
            logic [7:0] mis_q;
            logic [7:0] mis_d;
            logic [7:0] hold_q;
            logic [7:0] hold_d;
            logic       t_q;
            logic       t_d;
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;
            logic       deb_rise;
            logic       deb_fall;

            always_comb begin
                // Debounce: count consecutive disagreeing edges; any agreeing
                // edge, or the accepting edge itself, restarts the count.
                deb_d = deb_q;
                mis_d = 8'd0;
                if (s2_q != deb_q) begin
                    if (mis_q == DEB_LAST) begin
                        deb_d = ~deb_q;
                    end else begin
                        mis_d = mis_q + 8'd1;
                    end
                end

                deb_rise = deb_d & ~deb_q;
                deb_fall = ~deb_d & deb_q;

                // Hold stretcher: a re-rise cancels the window, but the flag
                // is already covered by deb_d so it never dips low.
                hold_d = hold_q;
                if (deb_rise) begin
                    hold_d = 8'd0;
                end else if (deb_fall) begin
                    hold_d = HOLD_INIT;
                end else if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                end

                t_d = deb_d | (hold_d != 8'd0);

                // Clear has priority over a coincident arrival.
                cnt_d = cnt_q;
                if (Clr) begin
                    cnt_d = 8'd0;
                end else if (deb_rise && (cnt_q != 8'hFF)) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    s1_q   <= 1'b0;
                    s2_q   <= 1'b0;
                    deb_q  <= 1'b0;
                    mis_q  <= 8'd0;
                    hold_q <= 8'd0;
                    t_q    <= 1'b0;
                    cnt_q  <= 8'd0;
                end else begin
                    s1_q   <= sens_raw[gi];
                    s2_q   <= s1_q;
                    deb_q  <= deb_d;
                    mis_q  <= mis_d;
                    hold_q <= hold_d;
                    t_q    <= t_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign t_w[gi]   = t_q;
            assign cnt_w[gi] = cnt_q;
        end
    endgenerate

    assign Ta   = t_w[0];
    assign Tb   = t_w[1];
    assign CntA = cnt_w[0];
    assign CntB = cnt_w[1];

endmodule

// File: doc/traffic_sensor_cond.md
TRAFFIC_SENSOR_COND -- requirements
Module: traffic_sensor_cond

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 4, giving the consecutive-cycle count a synchronized sensor level must persist before it is accepted (legal 1..255).
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 8, giving the cycles a conditioned output stays asserted after the debounced sensor falls (legal 0..255).
REQ-003 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SensA_raw  input  1  raw asynchronous car detector, street A.
REQ-006 SensB_raw  input  1  raw asynchronous car detector, street B.
REQ-007 Clr  input  1  synchronous clear of both car counters.
REQ-008 Ta  output  1  conditioned traffic-present flag, street A, registered; drives the downstream light controller.
REQ-009 Tb  output  1  conditioned traffic-present flag, street B, registered.
REQ-010 CntA  output  8  debounced car-arrival count, street A.
REQ-011 CntB  output  8  debounced car-arrival count, street B.

Function
REQ-012 Channels A and B SHALL be identical and fully independent; the requirements below are stated for A and apply equally to B.
REQ-013 SensA_raw SHALL pass through a two-flop synchronizer (s1, s2); no other logic SHALL sample SensA_raw.
REQ-014 A debounced level register deb SHALL toggle only on the DEB_CYCLES-th consecutive edge at which the pre-edge s2 differs from deb.
REQ-015 An 8-bit mismatch counter SHALL increment on each edge where s2 != deb and clear to 0 on any edge where s2 == deb, and also on the edge where deb toggles.
REQ-016 Latency: with SensA_raw held at a new level from before sampling edge k, deb SHALL change after edge k+1+DEB_CYCLES (k+5 at default).
REQ-017 A raw pulse or gap shorter than DEB_CYCLES synchronized cycles SHALL leave deb unchanged.
REQ-018 A hold counter SHALL load HOLD_CYCLES on the edge where deb falls 1->0, decrement by 1 per edge while nonzero, and clear to 0 on the edge where deb rises.
REQ-019 Ta SHALL be registered as (next deb) OR (next hold counter != 0), so Ta rises on the same edge as deb and falls exactly HOLD_CYCLES edges after deb falls (same edge when HOLD_CYCLES=0).
REQ-020 A deb re-rise during the hold window SHALL keep Ta continuously high, with no low cycle.
REQ-021 CntA SHALL increment by 1 on each edge where deb rises 0->1, saturate at 255, and never wrap.
REQ-022 Clr=1 SHALL set CntA and CntB to 0 on that edge; Clr coinciding with a deb rise SHALL yield 0 (clear wins).
REQ-023 Clr SHALL NOT affect synchronizers, deb, mismatch counters, hold counters, Ta or Tb.

Reset
REQ-024 Rst_n=0 SHALL immediately and asynchronously force s1, s2, deb, mismatch counters and hold counters to 0, and Ta=0, Tb=0, CntA=0, CntB=0.
REQ-025 Rst_n deassertion SHALL be followed by normal operation from the first subsequent posedge Clk; a sensor high at release is treated as a new level (REQ-016 latency, CntA increments).
REQ-026 Reset asserted mid-hold or mid-debounce SHALL discard that pending activity; no Ta pulse and no count SHALL result from it after release.

Verification
REQ-027 Defaults; SensA_raw 0->1 held before edge 10 -> Ta 0 through edge 14, 1 after edge 15; CntA 0->1 at edge 15; Tb, CntB unchanged.
REQ-028 Defaults; SensA_raw high for 3 cycles, then low -> Ta stays 0, CntA stays 0.
REQ-029 Defaults, Ta high; SensA_raw falls before edge 30 -> deb falls after edge 35, Ta stays 1 through edge 42, 0 after edge 43.
REQ-030 Defaults; SensB_raw low for 6 cycles inside its hold window, then high again -> Tb never drops, CntB increments once for the re-rise.
REQ-031 300 clean debounced arrivals on A with Clr=0 -> CntA=255, no wrap; Clr=1 on the edge of a further arrival -> CntA=0.
REQ-032 Rst_n pulsed low mid-hold with Ta=1 -> Ta, CntA, CntB 0 immediately, before any clock edge; with sensors low, Ta stays 0 after release.
